// File: rtl/issue_queue.sv
// In-order multi-issue queue with a GPR busy table; up to ISSUE_WIDTH oldest entries dispatch per cycle.
// Latency: at least 1 cycle from enqueue to issue; issue_* and stall_issue_o are combinational from state and inputs.
// Backpressure: in_ready_o is low while full (registered count); stall_i, fu_ready_i and hazards hold entries in place.
// Optional feature macro: ISSUE_QUEUE_WB_WAKEUP_EN (same-cycle writeback wakeup of dependent entries).
module issue_queue #(
  parameter int DEPTH       = 8,
  parameter int ISSUE_WIDTH = 2,
  parameter int NR_FU       = 4,
  parameter int NR_WB       = 2,
  parameter int PAYLOAD_W   = 64,
  localparam int FU_W       = $clog2(NR_FU),
  localparam int CNT_W      = $clog2(DEPTH + 1),
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic                             stall_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [PAYLOAD_W-1:0]             in_payload_i,
  input  logic [FU_W-1:0]                  in_fu_i,
  input  logic [4:0]                       in_rs1_i,
  input  logic [4:0]                       in_rs2_i,
  input  logic [4:0]                       in_rd_i,
  input  logic                             in_we_i,
  input  logic [NR_FU-1:0]                 fu_ready_i,
  output logic [ISSUE_WIDTH-1:0]           issue_valid_o,
  output logic [ISSUE_WIDTH*PAYLOAD_W-1:0] issue_payload_o,
  output logic [ISSUE_WIDTH*FU_W-1:0]      issue_fu_o,
  input  logic [NR_WB-1:0]                 wb_valid_i,
  input  logic [NR_WB*5-1:0]               wb_rd_i,
  output logic [CNT_W-1:0]                 count_o,
  output logic                             stall_issue_o
);

  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [FU_W-1:0]      fu_q      [DEPTH];
  logic [4:0]           rs1_q     [DEPTH];
  logic [4:0]           rs2_q     [DEPTH];
  logic [4:0]           rd_q      [DEPTH];
  logic [DEPTH-1:0]     we_q;

  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d, n_issue;
  logic [31:0]            busy_q, busy_d, busy_eff, wb_clr, wr_set;
  logic [NR_FU-1:0]       fu_claimed;
  logic [ISSUE_WIDTH-1:0] slot_go;
  logic                   enq;
  logic                   chain;

  // Space is judged from the registered count only, so issue never frees a slot in the same cycle
  assign in_ready_o    = (count_q < CNT_W'(DEPTH));
  assign enq           = in_valid_i & in_ready_o & ~flush_i;
  assign count_o       = count_q;
  assign issue_valid_o = slot_go;
  assign stall_issue_o = (count_q != '0) & ~slot_go[0] & ~stall_i;

  // Writeback clear mask, one bit per GPR
  always_comb begin
    wb_clr = '0;
    for (int p = 0; p < NR_WB; p++) begin
      if (wb_valid_i[p]) wb_clr[wb_rd_i[p*5 +: 5]] = 1'b1;
    end
  end

`ifdef ISSUE_QUEUE_WB_WAKEUP_EN
  assign busy_eff = busy_q & ~wb_clr;
`else
  assign busy_eff = busy_q;
`endif

  // Slot selection: a slot issues only if every older slot issued and it is free of FU and register hazards
  always_comb begin
    slot_go         = '0;
    n_issue         = '0;
    fu_claimed      = '0;
    wr_set          = '0;
    issue_payload_o = '0;
    issue_fu_o      = '0;
    chain           = ~(stall_i | flush_i);
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      logic [PTR_W-1:0] idx;
      logic [FU_W-1:0]  efu;
      logic [4:0]       ers1, ers2, erd;
      logic             ewe, hz;
      idx  = head_q + PTR_W'(k);
      efu  = fu_q[idx];
      ers1 = rs1_q[idx];
      ers2 = rs2_q[idx];
      erd  = rd_q[idx];
      ewe  = we_q[idx];
      issue_payload_o[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[idx];
      issue_fu_o[k*FU_W +: FU_W]                = efu;
      // wr_set holds rd of older issuing slots this cycle; bit 0 is never set
      hz = busy_eff[ers1] | busy_eff[ers2] | (ewe & busy_eff[erd])
         | wr_set[ers1] | wr_set[ers2] | wr_set[erd];
      chain = chain && (CNT_W'(k) < count_q) && fu_ready_i[efu] && !fu_claimed[efu] && !hz;
      if (chain) begin
        slot_go[k]      = 1'b1;
        n_issue         = n_issue + CNT_W'(1);
        fu_claimed[efu] = 1'b1;
        if (ewe && (erd != 5'd0)) wr_set[erd] = 1'b1;
      end
    end
  end

  // Pointer, occupancy and busy-table next state; a same-cycle set beats a writeback clear
  always_comb begin
    head_d    = head_q + PTR_W'(n_issue);
    tail_d    = tail_q + PTR_W'(enq);
    count_d   = count_q + CNT_W'(enq) - n_issue;
    busy_d    = (busy_q & ~wb_clr) | wr_set;
    busy_d[0] = 1'b0;
  end

  // Control state; reset and flush both empty the queue and clear the busy table
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  // Entry storage, written at tail on an accepted enqueue
  always_ff @(posedge clk_i) begin
    if (enq) begin
      payload_q[tail_q] <= in_payload_i;
      fu_q[tail_q]      <= in_fu_i;
      rs1_q[tail_q]     <= in_rs1_i;
      rs2_q[tail_q]     <= in_rs2_i;
      rd_q[tail_q]      <= in_rd_i;
      we_q[tail_q]      <= in_we_i;
    end
  end

endmodule
